muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Parametrised multi-cycle HI/LO multiply/divide unit in the Execute stage of the pipelined MIPS core.
//  Replaces the single-cycle combinational hilo coprocessor.
//  Executes mult/multu/div/divu iteratively and owns the architectural HI/LO registers.
//  Serves mfhi/mflo/mthi/mtlo, and asserts a stall request that the hazard unit ORs into stallF/stallD.
// PARAMETERS
//  WIDTH   32  operand and HI/LO width; must be even and >= 8
// PORTS
//  clk      in   1      core clock; all state changes on the rising edge
//  reset    in   1      synchronous, active-high; clears all state
//  startE   in   1      valid HI/LO-class instruction in Execute this cycle
//  functE   in   6      funct field of the Execute instruction
//  srcaE    in   WIDTH  forwarded rs value (dividend / multiplicand / mthi-mtlo data)
//  srcbE    in   WIDTH  forwarded rt value (divisor / multiplier)
//  hiloE    out  WIDTH  mfhi -> HI, mflo -> LO, otherwise 0; combinational from the HI/LO registers
//  busyE    out  1      iterative operation in flight
//  stallE   out  1      startE & busyE; holds the new HI/LO instruction in Execute
// BEHAVIOUR
//  Reset: state=IDLE; HI=LO=0; busyE=0; stallE=0; hiloE=0. Reset mid-operation abandons the op, no HI/LO write.
//  Funct codes: mfhi 0x10, mthi 0x11, mflo 0x12, mtlo 0x13, mult 0x18, multu 0x19, div 0x1A, divu 0x1B.
//   Other functs: ignored.
//  Accept rule: an op is accepted when startE & ~busyE; startE while busy is ignored (stallE=1).
//  mthi/mtlo: write HI/LO at the accepting edge; 0 cycles of busy.
//  mfhi/mflo: read-only; stalled while busyE so they never see a stale value.
//  FSM states: IDLE -> MUL | DIV (WIDTH iterations, 1 bit/cycle) -> FIX -> IDLE.
//   IDLE: on accepting mult*/div*, latch operand magnitudes and result-sign flags; count=WIDTH.
//   MUL: shift-add, one multiplier bit per cycle; count-- each cycle; go to FIX when count==1.
//   DIV: restoring divide; remainder shifted left with the next dividend bit.
//    Subtract the divisor if the result is non-negative, producing one quotient bit per cycle.
//   FIX: apply two's-complement sign correction; write {HI,LO}; go to IDLE.
//  Latency: accepted in cycle k -> busyE=1 in cycles k+1..k+WIDTH+1.
//   HI/LO are written at the end of cycle k+WIDTH+1; busyE=0 from cycle k+WIDTH+2.
//  Multiply: {HI,LO} = full 2*WIDTH product; signed for mult, unsigned for multu.
//  Divide: LO=quotient, HI=remainder. Signed div truncates toward zero; the remainder takes the dividend's sign.
//  Divide by zero: HI=dividend, LO=all ones. Same for signed and unsigned; no exception.
//  Signed overflow MIN/-1: LO=MIN, HI=0. This falls out of the magnitude path; no special case.
//  No kill input: once accepted, an op always completes (MIPS semantics). flushE does not affect the unit.
// CONFIGURATION
//  MULDIV_FAST_MUL_EN defined: mult/multu use a single-cycle array product.
//   The product is registered in MUL and written in FIX, so busyE=1 for cycles k+1..k+2 only.
//   div/divu are unchanged.
//  MULDIV_FAST_MUL_EN undefined: iterative multiply as above. No multiplier array is inferred.
// STRUCTURE
//  muldiv_pkg holds:
//   - funct localparams F_MFHI..F_DIVU
//   - typedef enum logic [1:0] {MD_IDLE, MD_MUL, MD_DIV, MD_FIX} md_state_t
//   - function is_md_op(funct)
//  Sub-module muldiv_iter (WIDTH): combinational single-step datapath.
//   Shift-add for MUL, trial-subtract for DIV, selected by state.
//   muldiv_unit keeps the FSM, counter, HI/LO and the sign fix-up.
// TESTING
//  multu 0xFFFFFFFF * 0xFFFFFFFF -> busyE for 33 cycles; then HI=0xFFFFFFFE, LO=0x00000001.
//  mult -3 * 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Back-to-back mflo during busy -> stallE=1 until done.
//   The mflo then returns 0xFFFFFFF1.
//  div -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 100 / 7 -> LO=14, HI=2.
//  divu 10 / 0 -> HI=0x0000000A, LO=0xFFFFFFFF. div 0x80000000 / -1 -> LO=0x80000000, HI=0.
//  mthi 0x1234; mtlo 0x5678; mfhi, mflo -> 0x1234, 0x5678; busyE never rises.
//  Start mult 6*7; pulse reset at iteration 10 -> busyE=0 next cycle, HI=LO=0.
//   A fresh multu 6*7 then gives LO=42.
//  With MULDIV_FAST_MUL_EN: the same multu gives LO=42 with busyE high for exactly 2 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: funct codes,
// FSM state encoding and the op-class decode helper.
package muldiv_pkg;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {MD_IDLE, MD_MUL, MD_DIV, MD_FIX} md_state_t;

  // True for the iterative (multi-cycle) multiply/divide ops.
  function automatic logic is_md_op(input logic [5:0] funct);
    return (funct == F_MULT) || (funct == F_MULTU) ||
           (funct == F_DIV)  || (funct == F_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage handshake between the pipeline and the HI/LO unit.
// master = pipeline side, slave = muldiv_unit.
interface muldiv_if #(parameter int WIDTH = 32);
  logic             startE;
  logic [5:0]       functE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic [WIDTH-1:0] hiloE;
  logic             busyE;
  logic             stallE;

  modport master (output startE, functE, srcaE, srcbE,
                  input  hiloE, busyE, stallE);
  modport slave  (input  startE, functE, srcaE, srcbE,
                  output hiloE, busyE, stallE);
endinterface

// File: rtl/muldiv_iter.sv
// One iteration of the shared HI/LO datapath, purely combinational.
// acc holds {upper, lower}:
//   MUL: upper = partial product, lower = remaining multiplier bits.
//   DIV: upper = partial remainder, lower = dividend bits / quotient bits.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_state_t          state_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,   // multiplicand or divisor magnitude
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // Shift-add multiply step or restoring-divide step, selected by state.
  always_comb begin
    sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} +
              (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
    // Remainder shifted left with the next dividend bit pulled in.
    shifted = acc_i[2*WIDTH-1:WIDTH-1];
    diff    = {1'b0, shifted} - {2'b00, opnd_i};
    acc_o   = acc_i;
    case (state_i)
      MD_MUL: acc_o = {sum, acc_i[WIDTH-1:1]};
      MD_DIV: begin
        // Negative trial difference: keep the shifted remainder, quotient bit 0.
        if (diff[WIDTH+1]) acc_o = {shifted[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
        else               acc_o = {diff[WIDTH-1:0],    acc_i[WIDTH-2:0], 1'b1};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit for the Execute stage.
// Owns HI/LO, serves mfhi/mflo/mthi/mtlo, and stalls new HI/LO ops while busy.
// Operates on magnitudes and applies the sign correction in a final FIX cycle.
// Optional: MULDIV_FAST_MUL_EN replaces the iterative multiply with a
// single-cycle array product (registered in MUL, written in FIX).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  md
);

  localparam int CW = $clog2(WIDTH + 1);

  md_state_t          state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q;
  logic               is_div_q, neg_lo_q, neg_hi_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               busy, accept, signed_op, a_neg, b_neg, div_op;
  logic [WIDTH-1:0]   a_mag, b_mag, fix_hi, fix_lo;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .state_i (state_q),
    .acc_i   (acc_q),
    .opnd_i  (opnd_q),
    .acc_o   (acc_d)
  );

  // Operand decode: magnitudes and sign flags for the incoming op.
  always_comb begin
    busy      = (state_q != MD_IDLE);
    accept    = md.startE & ~busy;
    div_op    = md.functE[1];
    signed_op = (md.functE == F_MULT) || (md.functE == F_DIV);
    a_neg     = signed_op & md.srcaE[WIDTH-1];
    b_neg     = signed_op & md.srcbE[WIDTH-1];
    a_mag     = a_neg ? -md.srcaE : md.srcaE;
    b_mag     = b_neg ? -md.srcbE : md.srcbE;
  end

  // Sign fix-up: full-width negate for products, per-half for quotient/remainder.
  always_comb begin
    if (!is_div_q) begin
      {fix_hi, fix_lo} = neg_lo_q ? -acc_q : acc_q;
    end else begin
      fix_lo = neg_lo_q ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
      fix_hi = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM, iteration counter and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (accept) begin
            if (md.functE == F_MTHI) hi_q <= md.srcaE;
            if (md.functE == F_MTLO) lo_q <= md.srcaE;
            if (is_md_op(md.functE)) begin
              is_div_q <= div_op;
              opnd_q   <= div_op ? b_mag : a_mag;
              acc_q    <= {{WIDTH{1'b0}}, (div_op ? a_mag : b_mag)};
              // Divide by zero keeps an all-ones quotient regardless of signs.
              neg_lo_q <= (a_neg ^ b_neg) & (~div_op | (|md.srcbE));
              neg_hi_q <= a_neg;
              cnt_q    <= CW'(WIDTH);
              state_q  <= div_op ? MD_DIV : MD_MUL;
            end
          end
        end
        MD_MUL: begin
`ifdef MULDIV_FAST_MUL_EN
          acc_q   <= {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]} * {{WIDTH{1'b0}}, opnd_q};
          state_q <= MD_FIX;
`else
          acc_q <= acc_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= MD_FIX;
`endif
        end
        MD_DIV: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= MD_FIX;
        end
        MD_FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          state_q <= MD_IDLE;
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  // Outputs: read mux straight off HI/LO, stall on a new op while busy.
  always_comb begin
    md.busyE  = busy;
    md.stallE = md.startE & busy;
    if (md.functE == F_MFHI)      md.hiloE = hi_q;
    else if (md.functE == F_MFLO) md.hiloE = lo_q;
    else                          md.hiloE = '0;
  end

endmodule
